path_queue_ctrl: RTL

//  Sequencer for the 2-bit move queue (queue_2bit): clears it, fills it from a

---
 rtl/path_queue_ctrl_pkg.sv | 34 +++
 rtl/path_queue_ctrl_pace_timer.sv | 31 +++
 rtl/path_queue_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/path_queue_ctrl_pkg.sv
// Shared types for the move-queue sequencer.
// State codes, move codes and a saturating counter helper.
package path_queue_ctrl_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_REWIND = 3'd3;
  localparam logic [2:0] S_REPLAY = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_CLEAR  = S_CLEAR,
    ST_FILL   = S_FILL,
    ST_REWIND = S_REWIND,
    ST_REPLAY = S_REPLAY,
    ST_DONE   = S_DONE,
    ST_ERROR  = S_ERROR
  } state_t;

  typedef logic [1:0] move_t;

  localparam move_t MV_UP    = 2'd0;
  localparam move_t MV_RIGHT = 2'd1;
  localparam move_t MV_DOWN  = 2'd2;
  localparam move_t MV_LEFT  = 2'd3;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/path_queue_ctrl_pace_timer.sv
// Replay pacing timer.
// Loads PACE-1 on a transfer, counts down to 0 and holds.
module pace_timer #(
  parameter int PACE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  output logic zero
);

  localparam int W = (PACE > 1) ? $clog2(PACE) : 1;
  localparam logic [W-1:0] LOAD_V = W'(PACE - 1);

  logic [W-1:0] cnt;

  // Countdown between transfers; clear forces immediate readiness.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_V;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/path_queue_ctrl.sv
// Sequencer for the 2-bit move queue.
// Clear, fill, rewind, then paced replay of stored moves.
module path_queue_ctrl
  import path_queue_ctrl_pkg::*;
#(
  parameter int DATA_W  = 2,
  parameter int PACE    = 4,
  parameter int REPLAYS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              move_valid,
  input  logic [DATA_W-1:0] move_in,
  input  logic              path_done,
  input  logic              out_ready,
  output logic [DATA_W-1:0] move_out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [7:0]        pass_cnt,
  output logic              q_rst,
  output logic              q_rst_front,
  output logic              q_enqueue,
  output logic              q_dequeue,
  output logic [DATA_W-1:0] q_data_in,
  input  logic [DATA_W-1:0] q_data_out,
  input  logic              q_finish,
  input  logic              q_full
);

  localparam logic [8:0] REP_LIM = 9'(REPLAYS);

  state_t st;
  state_t nxt;
  logic   q_rst_r;
  logic   q_rst_front_r;
  logic   pace_zero;
  logic   hs_en;
  logic   last_pass;
  logic   drop;

  assign hs_en     = ~rst & ~abort;
  assign last_pass = ({1'b0, pass_cnt} + 9'd1) >= REP_LIM;
  assign drop      = move_valid & q_full;

  assign out_valid   = hs_en & (st == ST_REPLAY)
                     & ~q_finish & pace_zero;
  assign q_dequeue   = out_valid & out_ready;
  assign q_enqueue   = hs_en & (st == ST_FILL)
                     & move_valid & ~q_full;
  assign q_rst       = rst | (q_rst_r & ~abort);
  assign q_rst_front = q_rst_front_r & hs_en;
  assign move_out    = q_data_out;
  assign q_data_in   = move_in;

  // Next-state selection; abort overrides everything.
  always_comb begin
    nxt = st;
    unique case (st)
      ST_IDLE:   if (start) nxt = ST_CLEAR;
      ST_CLEAR:  nxt = ST_FILL;
      ST_FILL: begin
        if (drop)           nxt = ST_ERROR;
        else if (path_done) nxt = ST_REWIND;
      end
      ST_REWIND: nxt = ST_REPLAY;
      ST_REPLAY: begin
        if (q_finish) nxt = last_pass ? ST_DONE : ST_REWIND;
      end
      ST_DONE,
      ST_ERROR:  if (start) nxt = ST_CLEAR;
      default:   nxt = ST_IDLE;
    endcase
    if (abort) nxt = ST_IDLE;
  end

  // State register with Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= ST_IDLE;
      q_rst_r       <= 1'b0;
      q_rst_front_r <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      st            <= nxt;
      q_rst_r       <= (nxt == ST_CLEAR);
      q_rst_front_r <= (nxt == ST_REWIND);
      busy          <= (nxt == ST_CLEAR) || (nxt == ST_FILL)
                    || (nxt == ST_REWIND) || (nxt == ST_REPLAY);
      done          <= (nxt == ST_DONE);
    end
  end

  // Sticky overflow flag and replay pass counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      pass_cnt <= 8'd0;
    end else if (!abort) begin
      if (st == ST_CLEAR) begin
        overflow <= 1'b0;
        pass_cnt <= 8'd0;
      end
      if (st == ST_FILL && drop) begin
        overflow <= 1'b1;
      end
      if (st == ST_REPLAY && q_finish) begin
        pass_cnt <= sat_inc(pass_cnt);
      end
    end
  end

  pace_timer #(
    .PACE (PACE)
  ) u_pace (
    .clk   (clk),
    .rst   (rst),
    .clear (st == ST_REWIND),
    .load  (q_dequeue),
    .zero  (pace_zero)
  );

endmodule
